// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
// Shared definitions for the HI/LO multiply/divide sequencer:
//   - operation codes presented on Op
//   - FSM state encoding
//   - default operand width and iteration count (one result bit per cycle)
// -----------------------------------------------------------------------------
package muldiv_pkg;

    localparam int MULDIV_WIDTH = 32;
    // One multiplier/quotient bit is produced per iteration.
    localparam int MULDIV_ITERS = MULDIV_WIDTH;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MADD  = 3'b100;
    localparam logic [2:0] OP_MSUB  = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DIV  = 2'b10,
        ST_FIX  = 2'b11
    } state_t;

endpackage

// File: rtl/muldiv_step.sv
// -----------------------------------------------------------------------------
// muldiv_step
// Combinational single iteration of the multi-cycle multiply/divide datapath.
//   is_mul   in  1        1: shift-add multiply step, 0: restoring divide step
//   acc      in  2*WIDTH  working register
//                         multiply: {partial product, remaining multiplier}
//                         divide  : {partial remainder, dividend/quotient}
//   operand  in  WIDTH    multiplicand (multiply) or divisor (divide)
//   acc_next out 2*WIDTH  working register after this iteration
// -----------------------------------------------------------------------------
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MULDIV_WIDTH
) (
    input  logic                 is_mul,
    input  logic [2*WIDTH-1:0]   acc,
    input  logic [WIDTH-1:0]     operand,
    output logic [2*WIDTH-1:0]   acc_next
);

    logic [WIDTH:0]   sum_s;
    logic [2*WIDTH:0] shifted_s;
    logic [WIDTH:0]   diff_s;

    // One iteration: add-then-shift-right for multiply, shift-left-then-trial-subtract for divide
    always_comb begin
        sum_s     = {1'b0, acc[2*WIDTH-1:WIDTH]}
                  + (acc[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
        shifted_s = {acc, 1'b0};
        // The shifted remainder needs WIDTH+1 bits; a borrow in diff_s marks a failed trial.
        diff_s    = shifted_s[2*WIDTH:WIDTH] - {1'b0, operand};
        if (is_mul) begin
            // Carry of the add becomes the new MSB as the product shifts right.
            acc_next = {sum_s, acc[WIDTH-1:1]};
        end else if (!diff_s[WIDTH]) begin
            acc_next = {diff_s[WIDTH-1:0], shifted_s[WIDTH-1:1], 1'b1};
        end else begin
            acc_next = shifted_s[2*WIDTH-1:0];
        end
    end

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// -----------------------------------------------------------------------------
// hilo_muldiv_ctrl
// Multi-cycle sequencer for MULT/MULTU/DIV/DIVU that owns the HI/LO registers.
// Iterative shift-add multiply and restoring divide, one bit per cycle:
// accept on edge 0, iterate on edges 1..WIDTH, write back on edge WIDTH+1.
//
// Ports:
//   Clk      in   1      clock, rising edge
//   Rst      in   1      asynchronous active-low reset
//   Start    in   1      request, accepted only when Busy=0 and Op is legal
//   Op       in   3      operation code (see muldiv_pkg)
//   A, B     in   WIDTH  rs / rt operands, sampled at accept
//   WrHi     in   1      MTHI strobe (honoured only while idle, no accepted Start)
//   WrLo     in   1      MTLO strobe (same rule)
//   WrData   in   WIDTH  MTHI/MTLO data
//   Busy     out  1      operation in flight
//   Done     out  1      one-cycle pulse coincident with Hi/Lo writeback
//   DivZero  out  1      pulses with Done for a divide with B=0
//   Hi, Lo   out  WIDTH  architectural HI/LO registers
//
// Build option: define HILO_MULACC_EN to make Op 100 (MADD) and 101 (MSUB)
// legal; both are signed and accumulate the product into {Hi,Lo}.
// -----------------------------------------------------------------------------
module hilo_muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MULDIV_WIDTH
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Start,
    input  logic [2:0]        Op,
    input  logic [WIDTH-1:0]  A,
    input  logic [WIDTH-1:0]  B,
    input  logic              WrHi,
    input  logic              WrLo,
    input  logic [WIDTH-1:0]  WrData,
    output logic              Busy,
    output logic              Done,
    output logic              DivZero,
    output logic [WIDTH-1:0]  Hi,
    output logic [WIDTH-1:0]  Lo
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    state_t               state_r;
    state_t               state_s;
    logic [2:0]           op_r;
    logic                 sign_a_r;
    logic                 sign_b_r;
    logic [WIDTH-1:0]     opnd_r;
    logic [2*WIDTH-1:0]   acc_r;
    logic [2*WIDTH-1:0]   acc_step_s;
    logic [CNT_W-1:0]     cnt_r;
    logic                 busy_r;
    logic                 done_r;
    logic                 divzero_r;
    logic [WIDTH-1:0]     hi_r;
    logic [WIDTH-1:0]     lo_r;

    logic                 legal_s;
    logic                 is_signed_s;
    logic                 is_div_s;
    logic                 accept_s;
    logic                 last_iter_s;
    logic [WIDTH-1:0]     a_mag_s;
    logic [WIDTH-1:0]     b_mag_s;
    logic [2*WIDTH-1:0]   prod_s;
    logic [WIDTH-1:0]     quo_s;
    logic [WIDTH-1:0]     rem_s;
    logic [2*WIDTH-1:0]   wb_s;
    logic                 divz_s;

    // Decode Op into legality, signedness and multiply/divide class
    always_comb begin
        legal_s     = 1'b0;
        is_signed_s = 1'b0;
        is_div_s    = 1'b0;
        case (Op)
            OP_MULT: begin
                legal_s     = 1'b1;
                is_signed_s = 1'b1;
            end
            OP_MULTU: begin
                legal_s     = 1'b1;
            end
            OP_DIV: begin
                legal_s     = 1'b1;
                is_signed_s = 1'b1;
                is_div_s    = 1'b1;
            end
            OP_DIVU: begin
                legal_s     = 1'b1;
                is_div_s    = 1'b1;
            end
`ifdef HILO_MULACC_EN
            OP_MADD, OP_MSUB: begin
                legal_s     = 1'b1;
                is_signed_s = 1'b1;
            end
`endif
            default: begin
                legal_s     = 1'b0;
            end
        endcase
    end

    assign accept_s    = Start & ~busy_r & legal_s;
    assign last_iter_s = (cnt_r == CNT_W'(WIDTH - 1));

    // Operand magnitudes: the iterative core works on unsigned values only
    always_comb begin
        if (is_signed_s && A[WIDTH-1]) begin
            a_mag_s = -A;
        end else begin
            a_mag_s = A;
        end
        if (is_signed_s && B[WIDTH-1]) begin
            b_mag_s = -B;
        end else begin
            b_mag_s = B;
        end
    end

    muldiv_step #(
        .WIDTH    (WIDTH)
    ) u_step (
        .is_mul   (state_r == ST_MUL),
        .acc      (acc_r),
        .operand  (opnd_r),
        .acc_next (acc_step_s)
    );

    // FSM state register
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_s = is_div_s ? ST_DIV : ST_MUL;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_MUL, ST_DIV: begin
                if (last_iter_s) begin
                    state_s = ST_FIX;
                end else begin
                    state_s = state_r;
                end
            end
            ST_FIX: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Sign correction and result mapping for the writeback cycle.
    // Unsigned ops latch both sign bits as 0, so no correction applies to them.
    // Divide by zero falls out naturally: quotient all ones, remainder = |A|.
    always_comb begin
        prod_s = (sign_a_r ^ sign_b_r) ? -acc_r : acc_r;
        quo_s  = (sign_a_r ^ sign_b_r) ? -acc_r[WIDTH-1:0] : acc_r[WIDTH-1:0];
        rem_s  = sign_a_r ? -acc_r[2*WIDTH-1:WIDTH] : acc_r[2*WIDTH-1:WIDTH];
        wb_s   = prod_s;
        divz_s = 1'b0;
        case (op_r)
            OP_DIV, OP_DIVU: begin
                wb_s   = {rem_s, quo_s};
                divz_s = (opnd_r == {WIDTH{1'b0}});
            end
`ifdef HILO_MULACC_EN
            OP_MADD: begin
                wb_s = {hi_r, lo_r} + prod_s;
            end
            OP_MSUB: begin
                wb_s = {hi_r, lo_r} - prod_s;
            end
`endif
            default: begin
                wb_s = prod_s;
            end
        endcase
    end

    // Datapath, counter, HI/LO and status registers
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            op_r      <= 3'b000;
            sign_a_r  <= 1'b0;
            sign_b_r  <= 1'b0;
            opnd_r    <= {WIDTH{1'b0}};
            acc_r     <= {(2*WIDTH){1'b0}};
            cnt_r     <= {CNT_W{1'b0}};
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            divzero_r <= 1'b0;
            hi_r      <= {WIDTH{1'b0}};
            lo_r      <= {WIDTH{1'b0}};
        end else begin
            done_r    <= 1'b0;
            divzero_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        // An accepted Start takes priority over MTHI/MTLO.
                        op_r     <= Op;
                        sign_a_r <= is_signed_s & A[WIDTH-1];
                        sign_b_r <= is_signed_s & B[WIDTH-1];
                        cnt_r    <= {CNT_W{1'b0}};
                        busy_r   <= 1'b1;
                        if (is_div_s) begin
                            opnd_r <= b_mag_s;
                            acc_r  <= {{WIDTH{1'b0}}, a_mag_s};
                        end else begin
                            opnd_r <= a_mag_s;
                            acc_r  <= {{WIDTH{1'b0}}, b_mag_s};
                        end
                    end else begin
                        if (WrHi) begin
                            hi_r <= WrData;
                        end else begin
                            hi_r <= hi_r;
                        end
                        if (WrLo) begin
                            lo_r <= WrData;
                        end else begin
                            lo_r <= lo_r;
                        end
                    end
                end
                ST_MUL, ST_DIV: begin
                    acc_r <= acc_step_s;
                    cnt_r <= cnt_r + CNT_W'(1);
                end
                ST_FIX: begin
                    hi_r      <= wb_s[2*WIDTH-1:WIDTH];
                    lo_r      <= wb_s[WIDTH-1:0];
                    done_r    <= 1'b1;
                    divzero_r <= divz_s;
                    busy_r    <= 1'b0;
                end
                default: begin
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign Busy    = busy_r;
    assign Done    = done_r;
    assign DivZero = divzero_r;
    assign Hi      = hi_r;
    assign Lo      = lo_r;

endmodule

// File: doc/hilo_muldiv_ctrl.md
Name: hilo_muldiv_ctrl

Overview:
- Multi-cycle sequencer for MIPS MULT/MULTU/DIV/DIVU; owns the architectural HI/LO registers.
- The single-cycle ALU handles all one-cycle ops; the decode stage steers mult/div here.
- The pipeline stalls on Busy; MFHI/MFLO read Hi/Lo directly.
- Uses an iterative shift-add multiplier and a restoring divider (one bit per cycle), so no combinational 64-bit multiplier sits in the execute stage.

Parameters:
- WIDTH, 32, operand/HI/LO width; latency scales with it.

Ports:
- Clk  in  1  clock, rising edge
- Rst  in  1  asynchronous, active-low reset
- Start  in  1  request; accepted only when Busy=0
- Op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MADD, 101 MSUB (MADD/MSUB only with the macro); other codes are ignored
- A  in  WIDTH  rs operand, sampled at accept
- B  in  WIDTH  rt operand, sampled at accept
- WrHi  in  1  MTHI write strobe
- WrLo  in  1  MTLO write strobe
- WrData  in  WIDTH  MTHI/MTLO data
- Busy  out  1  operation in flight; pipeline must stall
- Done  out  1  one-cycle pulse; Hi/Lo updated on the same edge
- DivZero  out  1  pulses with Done when a DIV/DIVU had B=0
- Hi  out  WIDTH  HI register
- Lo  out  WIDTH  LO register

Behaviour:
- Reset (asynchronous, Rst=0): state IDLE; Hi=0, Lo=0, Busy=0, Done=0, DivZero=0; internal accumulators cleared. Reset mid-operation aborts it; no Done is issued.
- States:
  - IDLE: on Start with a legal Op, go to MUL or DIV.
  - MUL / DIV: iterate WIDTH cycles.
  - FIX: apply sign correction and write back, then return to IDLE.
- Accept (edge 0, Start=1 and Busy=0):
  - Latch operand magnitudes (absolute values for signed ops), both sign bits and Op.
  - Busy=1 from edge 0.
- Iterations (edges 1..WIDTH):
  - MUL: 2*WIDTH-bit shift-add, LSB-first on the multiplier.
  - DIV: restoring; shift the remainder left, trial-subtract the divisor, set the quotient bit if the result is non-negative.
- FIX (edge WIDTH+1 = 33):
  - Write Hi/Lo, pulse Done, and drive Busy=0 on the same edge.
  - Total latency: 33 cycles from accept to result visible.
- Sign rules:
  - Product is negated if the sign bits differ (signed ops only).
  - Quotient is negated if the sign bits differ.
  - Remainder takes the sign of the dividend.
- Result mapping:
  - MULT/MULTU: Hi=product[63:32], Lo=product[31:0].
  - DIV/DIVU: Lo=quotient, Hi=remainder.
- Divide by zero: run the full 33 cycles; result Lo=32'hFFFFFFFF, Hi=A (for signed, after sign rules: Lo=FFFFFFFF if A>=0 else 1, Hi=A); DivZero=1 with Done.
- Signed overflow, 0x80000000 / 0xFFFFFFFF: Lo=0x80000000, Hi=0. No trap.
- Start while Busy=1: ignored; the in-flight op is unaffected. Start with an illegal Op: ignored, stays IDLE.
- WrHi/WrLo:
  - Busy=0: write on the edge; Hi and Lo may both be written in one cycle.
  - Busy=1: dropped.
  - Same cycle as an accepted Start: the write is dropped, because Start has priority.
- Back-to-back: Start may be asserted in the cycle after Done. It is accepted on the next edge, with a 1-cycle IDLE gap.
- Hi/Lo hold their value at all times except on writeback, MTHI/MTLO, and reset.

Optional Feature:
- Macro: HILO_MULACC_EN.
- Defined: Op 100 MADD and 101 MSUB are legal; both are signed.
  - The 64-bit product is added to or subtracted from {Hi,Lo} in the FIX cycle.
  - Same 33-cycle latency; wraps mod 2^64.
- Undefined: Op 100/101 are treated as illegal and ignored; there is no 64-bit adder in FIX.

Decomposition:
- Shared package muldiv_pkg:
  - Op code constants (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MADD, OP_MSUB).
  - State encoding (ST_IDLE, ST_MUL, ST_DIV, ST_FIX).
  - Iteration-count constant.
- One sub-module, muldiv_step: combinational single-iteration datapath (shift-add step / restoring subtract step) selected by a mul/div flag. The controller holds the FSM, counter, registers and sign fix.

Test Plan:
- MULT A=-3 (FFFFFFFD), B=5 -> Busy high 33 cycles; Done on edge 33; Hi=FFFFFFFF, Lo=FFFFFFF1.
- MULTU A=B=FFFFFFFF -> Hi=FFFFFFFE, Lo=00000001. MULT same operands -> Hi=0, Lo=1.
- DIV A=-7, B=2 -> Lo=FFFFFFFD, Hi=FFFFFFFF. DIVU A=7, B=0 -> Lo=FFFFFFFF, Hi=7, DivZero=1 with Done.
- Busy interference: Start DIVU 100/7; at cycle 5 pulse Start(MULT), WrHi=1 with WrData=DEADBEEF -> both ignored; result Lo=14, Hi=2. Then, idle, WrLo=1234 -> Lo=1234 next edge.
- Reset mid-op: Rst low at cycle 10 of a MULT -> immediately Busy=0, Hi=Lo=0. Release, new MULT 2*3 -> Lo=6, Done at 33.
- HILO_MULACC_EN: {Hi,Lo}=0:10, MADD 4*5 -> Lo=30, Hi=0. Then MSUB 8*4 -> Hi=FFFFFFFF, Lo=FFFFFFFE.
